// File: rtl/sramlike_mem_slave.sv
// sramlike_mem_slave: SRAM-like memory responder with fixed-latency,
// in-order responses and byte-lane writes.
// Ports: clk, rst (async, active-low), req/wr/size/addr/wdata (request),
//   addr_ok (comb accept), data_ok/rdata/err (response from last stage).
module sramlike_mem_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            strb;
  logic                  mis;
  logic                  accept;

  logic        vld  [LATENCY];
  logic [31:0] pRd  [LATENCY];
  logic        pErr [LATENCY];

  // upper address bits alias onto the same words
  logic unusedAddr;
  assign unusedAddr = ^addr[31:ADDR_WIDTH+2];

  assign idx = addr[ADDR_WIDTH+1:2];

  // a response leaving this cycle frees its slot for a new accept
  assign addr_ok = req & ((count < CW'(DEPTH)) | data_ok);
  assign accept  = req & addr_ok;

  always_comb begin
    strb = 4'b0000;
    mis  = 1'b0;
    unique case (size)
      2'd0: strb = 4'b0001 << addr[1:0];
      2'd1: begin
        if (addr[0]) mis  = 1'b1;
        else         strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        if (addr[1:0] != 2'b00) mis  = 1'b1;
        else                    strb = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld[i]  <= 1'b0;
        pRd[i]  <= '0;
        pErr[i] <= 1'b0;
      end
    end else begin
      vld[0]  <= accept;
      pRd[0]  <= (accept && !wr && !mis) ? mem[idx] : '0;
      pErr[0] <= accept && mis;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        pRd[i]  <= pRd[i-1];
        pErr[i] <= pErr[i-1];
      end
    end
  end

  assign data_ok = vld[LATENCY-1];
  assign rdata   = pRd[LATENCY-1];
  assign err     = pErr[LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case ({accept, data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
